// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a JK driver: each {op,rep} entry drives J/K
// for rep+1 cycles, back-to-back, while tracking the downstream Q.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [2:0]               cmd_rep,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic                     done,
  output logic                     q_model,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [4:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;
  logic [2:0]      cnt_q;
  logic [2:0]      cnt_d;
  logic            j_q;
  logic            k_q;
  logic            j_d;
  logic            k_d;
  logic            q_q;
  logic            q_d;
  logic            push;
  logic            pop;
  logic            empty;
  logic [4:0]      head;

  assign empty     = (level_q == '0);
  assign cmd_ready = (level_q != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rptr];

  assign J       = j_q;
  assign K       = k_q;
  assign q_model = q_q;
  assign level   = level_q;
  assign busy    = (state_q == DRIVE);
  assign done    = (state_q == DRIVE) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Head is popped and loaded on the same edge, so commands run gap-free.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          j_d     = head[4];
          k_d     = head[3];
          cnt_d   = head[2:0];
          state_d = DRIVE;
        end else begin
          j_d = 1'b0;
          k_d = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (!empty) begin
          pop   = 1'b1;
          j_d   = head[4];
          k_d   = head[3];
          cnt_d = head[2:0];
        end else begin
          j_d     = 1'b0;
          k_d     = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_d = q_q;
    unique case ({j_q, k_q})
      2'b00: q_d = q_q;
      2'b01: q_d = 1'b0;
      2'b10: q_d = 1'b1;
      2'b11: q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {cmd_op, cmd_rep};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      q_q     <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      level_q <= level_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      q_q     <= q_d;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: directed scenarios plus random traffic
// against a queue/remaining-cycles reference model.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [2:0]    cmd_rep = '0;
  logic          cmd_ready;
  logic          J;
  logic          K;
  logic          busy;
  logic          done;
  logic          q_model;
  logic [LW-1:0] level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rep   (cmd_rep),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .done      (done),
    .q_model   (q_model),
    .level     (level)
  );

  logic [4:0] fq[$];
  logic [4:0] act;
  int         left;
  logic       mj;
  logic       mk;
  logic       mqv;
  logic [4:0] exp_done[$];
  logic [4:0] obs_done[$];
  logic [4:0] obs_s[$];
  logic [4:0] cmds[10];

  int         jhi, j11, dn, hold_n, hold_q1, nr, maxl, lvl2;
  logic [6:0] qlog;
  int         run_len;
  logic [1:0] run_op;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_vec();
    return {18'd0, mj, mk, left != 0, left == 1, mqv,
            fq.size() != DEPTH, 8'(fq.size())};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {18'd0, J, K, busy, done, q_model, cmd_ready, 8'(level)};
  endfunction

  task automatic model_reset();
    fq.delete();
    left = 0;
    mj   = 1'b0;
    mk   = 1'b0;
    mqv  = 1'b0;
    act  = '0;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] op,
                            input logic [2:0] rep);
    logic acc;
    acc = v && (fq.size() != DEPTH);
    case ({mj, mk})
      2'b01:   mqv = 1'b0;
      2'b10:   mqv = 1'b1;
      2'b11:   mqv = ~mqv;
      default: ;
    endcase
    if (left > 1) begin
      left--;
    end else if (fq.size() > 0) begin
      act  = fq.pop_front();
      mj   = act[4];
      mk   = act[3];
      left = int'(act[2:0]) + 1;
    end else begin
      left = 0;
      mj   = 1'b0;
      mk   = 1'b0;
    end
    if (acc) fq.push_back({op, rep});
  endtask

  task automatic sample();
    chk("outs", obs_vec(), exp_vec());
    if (left == 1) exp_done.push_back(act);
    if (J && !K) jhi++;
    if (J && K) j11++;
    if (done) dn++;
    if (busy && !J && !K) begin
      hold_n++;
      if (q_model) hold_q1++;
    end
    if (!cmd_ready) nr++;
    if (int'(level) > maxl) maxl = int'(level);
    if (level == LW'(2)) lvl2++;
    qlog = {qlog[5:0], q_model};
    if (!rst_n) begin
      run_len = 0;
    end else if (busy) begin
      if (run_len == 0) run_op = {J, K};
      run_len++;
      if (done) begin
        obs_done.push_back({run_op, 3'(run_len - 1)});
        obs_s.push_back({run_op, 3'(run_len - 1)});
        run_len = 0;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] op,
                     input logic [2:0] rep);
    cmd_valid = v;
    cmd_op    = op;
    cmd_rep   = rep;
    @(posedge clk);
    if (rst_n) model_edge(v, op, rep);
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'($urandom), 3'($urandom));
  endtask

  task automatic clr();
    jhi = 0; j11 = 0; dn = 0; hold_n = 0; hold_q1 = 0;
    nr = 0; maxl = 0; lvl2 = 0; qlog = '0;
    obs_s.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    sample();
    repeat (n) cyc(1'($urandom), 2'($urandom), 3'($urandom));
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    run_len = 0;
    run_op  = '0;
    clr();
    @(negedge clk);
    sample();
    cyc(1'b1, 2'b11, 3'd5);
    cyc(1'b1, 2'b10, 3'd1);
    rst_n = 1'b1;

    // set, rep 2
    clr();
    cyc(1'b1, 2'b10, 3'd2);
    idle(5);
    chk("s1_jhi", jhi, 3);
    chk("s1_done", dn, 1);
    chk("s1_q", q_model, 1);
    chk("s1_busy", busy, 0);

    // three toggles back to back
    do_reset(2);
    clr();
    repeat (3) cyc(1'b1, 2'b11, 3'd0);
    idle(4);
    chk("s2_j11", j11, 3);
    chk("s2_done", dn, 3);
    chk("s2_qseq", qlog, 7'b0010111);

    // fill while a long command runs
    clr();
    cyc(1'b1, 2'b10, 3'd7);
    repeat (11) cyc(1'b1, 2'($urandom), 3'd7);
    chk("s3_maxlvl", maxl, DEPTH);
    chk("s3_notready", nr, 7);
    idle(45);
    chk("s3_drained", level, 0);

    // push and pop together at level 2, wrapping pointers
    clr();
    cmds[0] = {2'($urandom), 3'd1};
    for (int i = 1; i < 10; i++) cmds[i] = {2'($urandom), 3'd0};
    for (int i = 0; i < 10; i++) cyc(1'b1, cmds[i][4:3], cmds[i][2:0]);
    idle(6);
    chk("s4_lvl2", lvl2, 8);
    chk("s4_n", obs_s.size(), 10);
    for (int i = 0; i < 10 && i < obs_s.size(); i++)
      chk("s4_order", obs_s[i], cmds[i]);

    // reset mid-command with three queued
    clr();
    cyc(1'b1, 2'b10, 3'd7);
    repeat (3) cyc(1'b1, 2'b11, 3'd2);
    chk("s5_lvl", level, 3);
    do_reset(2);
    chk("s5_nodone", dn, 0);
    clr();
    cyc(1'b1, 2'b01, 3'd0);
    idle(3);
    chk("s5_after", dn, 1);

    // hold between set and clear
    clr();
    cyc(1'b1, 2'b10, 3'd0);
    cyc(1'b1, 2'b00, 3'd3);
    cyc(1'b1, 2'b01, 3'd0);
    idle(8);
    chk("s6_hold", hold_n, 4);
    chk("s6_holdq", hold_q1, 4);
    chk("s6_q", q_model, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0)
        do_reset($urandom_range(1, 3));
      else
        cyc($urandom_range(0, 9) < 6, 2'($urandom), 3'($urandom));
    end
    idle(80);

    chk("ndone", obs_done.size(), exp_done.size());
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++)
      chk("done_order", obs_done[i], exp_done[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
